// File: rtl/input_tick_gen.sv
// Button conditioning (sync, debounce, up-press latch) and two-phase game tick
// strobe generator feeding the player controller and physics.
module input_tick_gen #(
    parameter int unsigned TICK_PERIOD     = 416667,
    parameter int unsigned TICK_W          = 19,
    parameter int unsigned DEBOUNCE_CYCLES = 65535,
    parameter int unsigned DEB_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    input  logic       pause,
    output logic [1:0] game_tick,
    output logic       button_up,
    output logic       button_down
);

    localparam int unsigned NUM_BTN = 2;
    localparam int unsigned BTN_UP  = 0;
    localparam int unsigned BTN_DN  = 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0]            raw_c;
    logic [NUM_BTN-1:0]            s1;
    logic [NUM_BTN-1:0]            s2;
    logic [NUM_BTN-1:0]            stb;
    logic [NUM_BTN-1:0][DEB_W-1:0] dcnt;
    logic [NUM_BTN-1:0][DEB_W-1:0] dcnt_nxt_c;
    logic [NUM_BTN-1:0]            flip_c;
    logic                          up_rise_c;
    logic                          pend;
    logic [TICK_W-1:0]             tcnt;
    logic                          tick_wrap_c;

    assign raw_c = {btn_down_raw, btn_up_raw};

    // Debounce: count consecutive cycles the synchronised level disagrees with stb
    always_comb begin
        flip_c     = '0;
        dcnt_nxt_c = '0;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            if (s2[i] != stb[i]) begin
                if (dcnt[i] == DEB_LAST) begin
                    flip_c[i] = 1'b1;
                end else begin
                    dcnt_nxt_c[i] = dcnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // A flip while s2 is high is necessarily a 0->1 transition of the stable level
    assign up_rise_c   = flip_c[BTN_UP] & s2[BTN_UP];
    assign tick_wrap_c = !pause && (tcnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            stb       <= '0;
            dcnt      <= '0;
            pend      <= 1'b0;
            tcnt      <= '0;
            game_tick <= 2'b00;
        end else begin
            s1   <= raw_c;
            s2   <= s1;
            stb  <= stb ^ flip_c;
            dcnt <= dcnt_nxt_c;

            // Set wins over clear: a press arriving on a tick edge was not seen by that tick
            if (up_rise_c) begin
                pend <= 1'b1;
            end else if (game_tick[0]) begin
                pend <= 1'b0;
            end

            if (!pause) begin
                tcnt <= (tcnt == TICK_LAST) ? '0 : tcnt + TICK_W'(1);
            end

            // Phase 1 follows phase 0 unconditionally so a pair is never split by pause
            game_tick <= {game_tick[0], tick_wrap_c};
        end
    end

    assign button_up   = stb[BTN_UP] | pend;
    assign button_down = stb[BTN_DN];

endmodule

// File: tb/tb_input_tick_gen.sv
// Self-checking bench for input_tick_gen: per-cycle expected outputs are queued
// from the stimulus plan and popped against the DUT each cycle.
module tb_input_tick_gen;

    localparam int unsigned TP  = 8;
    localparam int unsigned DBC = 4;

    typedef struct packed {
        logic [1:0] gt;
        logic       up;
        logic       dn;
    } obs_t;

    logic       clk;
    logic       reset;
    logic       btn_up_raw;
    logic       btn_down_raw;
    logic       pause;
    logic [1:0] game_tick;
    logic       button_up;
    logic       button_down;

    obs_t exp_q[$];
    int   n_cmp;
    int   n_err;

    input_tick_gen #(
        .TICK_PERIOD    (TP),
        .TICK_W         (4),
        .DEBOUNCE_CYCLES(DBC),
        .DEB_W          (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_up_raw  (btn_up_raw),
        .btn_down_raw(btn_down_raw),
        .pause       (pause),
        .game_tick   (game_tick),
        .button_up   (button_up),
        .button_down (button_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        reset        = 1'b1;
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        pause        = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e;
        obs_t o;
        exp_q.delete();
        reset        = 1'b1;
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        pause        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            o = {game_tick, button_up, button_down};
            n_cmp++;
            if (o !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: got gt=%b up=%b dn=%b, want all 0",
                         i, o.gt, o.up, o.dn);
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 28; c++) begin
            e.gt[0] = (c == 8 || c == 16 || c == 24);
            e.gt[1] = (c == 9 || c == 17 || c == 25);
            e.up    = 1'b0;
            e.dn    = 1'b0;
            exp_q.push_back(e);
        end
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            o = {game_tick, button_up, button_down};
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset_ticks c=%0d: got gt=%b up=%b dn=%b, want gt=%b up=%b dn=%b",
                         c, o.gt, o.up, o.dn, e.gt, e.up, e.dn);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_debounce();
        obs_t e;
        obs_t o;
        exp_q.delete();
        apply_reset();
        for (int c = 0; c < 35; c++) begin
            e.gt[0] = (c == 8 || c == 16 || c == 24 || c == 32);
            e.gt[1] = (c == 9 || c == 17 || c == 25 || c == 33);
            e.up    = (c >= 8);
            e.dn    = (c >= 28 && c <= 31);
            exp_q.push_back(e);
        end
        for (int c = 0; c < 35; c++) begin
            btn_up_raw   = (c >= 2);
            btn_down_raw = (c >= 10 && c <= 12) || (c >= 22 && c <= 25);
            @(negedge clk);
            o = {game_tick, button_up, button_down};
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL debounce c=%0d: got gt=%b up=%b dn=%b, want gt=%b up=%b dn=%b",
                         c, o.gt, o.up, o.dn, e.gt, e.up, e.dn);
            end
            @(posedge clk);
            #1;
        end
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
    endtask

    // Short press whose stable level ends before the tick; only the latch holds it
    task automatic test_latch();
        obs_t e;
        obs_t o;
        exp_q.delete();
        apply_reset();
        for (int c = 0; c < 31; c++) begin
            e.gt[0] = (c == 8 || c == 16 || c == 24);
            e.gt[1] = (c == 9 || c == 17 || c == 25);
            e.up    = (c >= 18 && c <= 24);
            e.dn    = 1'b0;
            exp_q.push_back(e);
        end
        for (int c = 0; c < 31; c++) begin
            btn_up_raw = (c >= 12 && c <= 17);
            @(negedge clk);
            o = {game_tick, button_up, button_down};
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL latch c=%0d: got gt=%b up=%b dn=%b, want gt=%b up=%b dn=%b",
                         c, o.gt, o.up, o.dn, e.gt, e.up, e.dn);
            end
            @(posedge clk);
            #1;
        end
        btn_up_raw = 1'b0;
    endtask

    task automatic test_pause();
        obs_t e;
        obs_t o;
        exp_q.delete();
        apply_reset();
        for (int c = 0; c < 36; c++) begin
            e.gt[0] = (c == 13 || c == 21 || c == 32);
            e.gt[1] = (c == 14 || c == 22 || c == 33);
            e.up    = 1'b0;
            e.dn    = 1'b0;
            exp_q.push_back(e);
        end
        for (int c = 0; c < 36; c++) begin
            pause = (c >= 3 && c <= 7) || (c == 21 || c == 22) || (c == 30);
            @(negedge clk);
            o = {game_tick, button_up, button_down};
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL pause c=%0d: got gt=%b up=%b dn=%b, want gt=%b up=%b dn=%b",
                         c, o.gt, o.up, o.dn, e.gt, e.up, e.dn);
            end
            @(posedge clk);
            #1;
        end
        pause = 1'b0;
    endtask

    // Up stable level rises on the same edge game_tick[0] is high
    task automatic test_collision();
        obs_t e;
        obs_t o;
        exp_q.delete();
        apply_reset();
        for (int c = 0; c < 31; c++) begin
            e.gt[0] = (c == 8 || c == 16 || c == 24);
            e.gt[1] = (c == 9 || c == 17 || c == 25);
            e.up    = (c >= 17 && c <= 24);
            e.dn    = 1'b0;
            exp_q.push_back(e);
        end
        for (int c = 0; c < 31; c++) begin
            btn_up_raw = (c >= 11 && c <= 16);
            @(negedge clk);
            o = {game_tick, button_up, button_down};
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL collision c=%0d: got gt=%b up=%b dn=%b, want gt=%b up=%b dn=%b",
                         c, o.gt, o.up, o.dn, e.gt, e.up, e.dn);
            end
            @(posedge clk);
            #1;
        end
        btn_up_raw = 1'b0;
    endtask

    task automatic test_mid_reset();
        obs_t e;
        obs_t o;
        exp_q.delete();
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            e.gt[0] = (c == 8 || c == 17);
            e.gt[1] = (c == 18);
            e.up    = 1'b0;
            e.dn    = 1'b0;
            exp_q.push_back(e);
        end
        for (int c = 0; c < 20; c++) begin
            reset = (c == 8);
            @(negedge clk);
            o = {game_tick, button_up, button_down};
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL mid_reset c=%0d: got gt=%b up=%b dn=%b, want gt=%b up=%b dn=%b",
                         c, o.gt, o.up, o.dn, e.gt, e.up, e.dn);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        reset        = 1'b1;
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        pause        = 1'b0;
        test_reset();
        test_debounce();
        test_latch();
        test_pause();
        test_collision();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/input_tick_gen.md
# input_tick_gen

Front-end conditioning stage feeding the player controller and physics. It synchronises and debounces the raw up/down button pins, and latches short up-presses so they are never lost between game ticks. It also generates the two-phase `game_tick[1:0]` strobe: velocity update on phase 0, position update on phase 1. All outputs connect directly to the controller's `game_tick`, `button_up` and `button_down` inputs.

## Interface

Parameters:
- `TICK_PERIOD`, default 416667: clock cycles between successive `game_tick[0]` pulses (60 Hz at 25 MHz); must be ≥ 3.
- `TICK_W`, default 19: width of the tick counter; must satisfy 2^TICK_W ≥ TICK_PERIOD.
- `DEBOUNCE_CYCLES`, default 65535: consecutive cycles a synchronised input must differ from its stable value before the stable value flips; must be ≥ 1.
- `DEB_W`, default 16: width of each debounce counter.

Ports:
- `clk` in 1: system clock. The block uses one clock.
- `reset` in 1: synchronous, active-high reset.
- `btn_up_raw` in 1: asynchronous up/jump button pin, active high.
- `btn_down_raw` in 1: asynchronous down/duck button pin, active high.
- `pause` in 1: when high, freezes tick generation.
- `game_tick` out 2: bit 0 is the velocity strobe; bit 1 is the position strobe, issued one cycle after bit 0.
- `button_up` out 1: debounced up level OR pending-press latch.
- `button_down` out 1: debounced down level.

## Operation

- **Synchroniser:** each raw pin passes through a 2-FF synchroniser (`s1` → `s2`). Both stages reset to 0.
- **Debounce** (one instance per button, counter `dcnt`, stable register `stb`):
  - `s2 == stb`: `dcnt` ← 0.
  - `s2 != stb` and `dcnt == DEBOUNCE_CYCLES-1`: `stb` ← `s2`, `dcnt` ← 0.
  - Otherwise `dcnt` increments.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles restarts the count; the stable value does not change.
- **Up-press latch `pend`:**
  - Set on the edge where the up `stb` goes 0→1.
  - Cleared on any edge where `game_tick[0]` is high.
  - If both happen on the same edge, set wins: the new level was not visible during that tick cycle.
- **Output equations:**
  - `button_up` = `stb_up | pend`. This is a combinational OR of registers.
  - `button_down` = `stb_down`. Duck is level-only and has no latch.
- **Tick counter `tcnt`** (0..TICK_PERIOD-1):
  - When `pause` is low, `tcnt` increments, wrapping from TICK_PERIOD-1 to 0.
  - When `pause` is high, `tcnt` holds.
- **Tick strobes:**
  - `game_tick[0]` is registered. It goes high for one cycle on the edge where `tcnt` wraps (`tcnt == TICK_PERIOD-1` and `pause` low).
  - `game_tick[1]` is registered as `game_tick[0]` delayed one cycle.
  - `game_tick[1]` ignores `pause`, so a tick pair is never split.
- **Reset values:** every register resets to 0. Outputs are therefore `game_tick = 2'b00`, `button_up = 0` and `button_down = 0` from the first cycle reset is sampled high.

## Timing

- **Button latency:** a raw edge reaches `stb` (and the outputs) 2 + `DEBOUNCE_CYCLES` clock edges after the raw pin changes, given a stable input and sampling aligned to the clock.
- **First tick:** after reset deasserts, the first `game_tick[0]` is high in cycle index `TICK_PERIOD` (cycle 0 is the first non-reset cycle). `game_tick[1]` is high in cycle `TICK_PERIOD+1`.
- **Tick spacing:** `game_tick[0]` period is exactly `TICK_PERIOD` cycles while `pause` is low. Each period contributes one cycle to each strobe; the bits are never high in the same cycle.
- **Pause:**
  - Asserting `pause` holds `tcnt`. Cycles with `pause` high extend the current period one-for-one.
  - `pause` high in the wrap cycle suppresses `game_tick[0]`; the pulse fires on the first unpaused cycle at the wrap value.
  - `pause` asserted in the cycle `game_tick[0]` is high still yields `game_tick[1]` in the next cycle.
- **Short press:** an up-press that is debounced and released entirely between two `game_tick[0]` pulses is still presented. `button_up` stays high through the next `game_tick[0]` cycle and drops the cycle after, unless the stable level is still high.
- **Mid-operation reset:** reset asserted at any point clears the counters, the latch and the synchronisers on that edge. No partial tick pair follows reset; `game_tick[1]` is 0 even if `game_tick[0]` was high the cycle before.

## Test plan

Tests 1–5 use `TICK_PERIOD` = 8 and `DEBOUNCE_CYCLES` = 4.

1. **Reset:** hold `reset` 3 cycles then release, with no buttons pressed → `game_tick[0]` high only in cycles 8, 16, 24; `game_tick[1]` high only in cycles 9, 17, 25; both buttons read 0 throughout.
2. **Debounce:** raise `btn_up_raw` at cycle 2 and hold → `button_up` rises at cycle 8 (2 sync + 4 debounce). A 3-cycle pulse on `btn_down_raw` → `button_down` stays 0.
3. **Latch:** press up for 6 cycles starting just after a tick → `button_up` stays high until the next `game_tick[0]` cycle inclusive, then goes 0.
4. **Pause:** assert `pause` for 5 cycles starting at `tcnt` = 3 → next `game_tick[0]` is delayed by exactly 5 cycles (cycle 13 instead of 8). Separately, `pause` asserted during a `game_tick[0]` cycle → `game_tick[1]` still fires next cycle.
5. **Set/clear collision:** arrange for the up `stb` 0→1 transition to land on the same edge where `game_tick[0]` is high → `pend` = 1 afterwards, and `button_up` remains 1 through the following `game_tick[0]`.
6. **Mid-pair reset:** assert `reset` on the cycle `game_tick[0]` is high → `game_tick[1]` = 0 next cycle. After release, the first `game_tick[0]` again occurs `TICK_PERIOD` cycles later.
